checkpoint_monitor: RTL

CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

---
 rtl/checkpoint_monitor.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor
// Watches the firmware status word (checkbits) for phase start/end markers.
// For each of six phases it records the latency in clock edges between the
// start and end markers and the number of data-word changes seen between them.
// Marker format: 16'hAB00 + (n<<4) opens phase n, 16'hAB01 + (n<<4) closes it.
// Records are read back combinationally through rd_sel.

module checkpoint_monitor (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] checkbits,
    input  logic [2:0]  rd_sel,
    output logic [31:0] rd_lat,
    output logic [7:0]  rd_wcnt,
    output logic [5:0]  done,
    output logic        busy,
    output logic [2:0]  active_id,
    output logic        err
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_ACTIVE = 1'b1;
    localparam logic [31:0] CYC_MAX   = 32'hFFFF_FFFF;
    localparam logic [7:0]  WRD_MAX   = 8'hFF;
    localparam int          N_PHASE   = 6;

    // A marker word: 0xAB in the top byte, phase 0..5 in bits [7:4] and the
    // marker kind (0 = start, 1 = end) in the low nibble.
    function automatic logic is_marker(input logic [15:0] word, input logic [3:0] kind);
        return (word[15:8] == 8'hAB) && (word[3:0] == kind) && (word[7:4] <= 4'd5);
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0] prev_r;
    logic [0:0]  state_r;
    logic [2:0]  id_r;
    logic [31:0] cyc_r;
    logic [7:0]  wrd_r;
    logic [31:0] lat_r  [0:N_PHASE-1];
    logic [7:0]  wcnt_r [0:N_PHASE-1];
    logic [5:0]  done_r;
    logic        err_r;
    logic        busy_r;
    logic [2:0]  active_id_r;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic        event_s;
    logic        start_ev_s;
    logic        end_ev_s;
    logic        data_ev_s;
    logic [2:0]  phase_s;

    // Classify the current edge: any change of checkbits is an event, split
    // into start marker, end marker or plain data word.
    always_comb begin
        event_s    = (checkbits != prev_r);
        phase_s    = checkbits[6:4];
        start_ev_s = event_s && is_marker(checkbits, 4'h0);
        end_ev_s   = event_s && is_marker(checkbits, 4'h1);
        data_ev_s  = event_s && !start_ev_s && !end_ev_s;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [0:0]  state_nx_s;
    logic [2:0]  id_nx_s;
    logic [31:0] cyc_nx_s;
    logic [7:0]  wrd_nx_s;
    logic        rec_s;
    logic        err_set_s;

    // Phase tracking FSM: opens a phase on a start marker, counts edges and
    // data words while open, and records on the matching end marker. Any
    // out-of-protocol marker raises the sticky error and discards the phase.
    always_comb begin
        state_nx_s = state_r;
        id_nx_s    = id_r;
        cyc_nx_s   = cyc_r;
        wrd_nx_s   = wrd_r;
        rec_s      = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_s) begin
                    state_nx_s = ST_ACTIVE;
                    id_nx_s    = phase_s;
                    cyc_nx_s   = 32'd1;
                    wrd_nx_s   = 8'd0;
                end else if (end_ev_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    // data words while idle are ignored
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (start_ev_s) begin
                    // nested start: drop the open phase and restart
                    err_set_s  = 1'b1;
                    state_nx_s = ST_ACTIVE;
                    id_nx_s    = phase_s;
                    cyc_nx_s   = 32'd1;
                    wrd_nx_s   = 8'd0;
                end else if (end_ev_s) begin
                    state_nx_s = ST_IDLE;
                    if (phase_s == id_r) begin
                        rec_s     = 1'b1;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end else begin
                    if (cyc_r != CYC_MAX) begin
                        cyc_nx_s = cyc_r + 32'd1;
                    end else begin
                        cyc_nx_s = cyc_r;
                    end
                    if (data_ev_s && (wrd_r != WRD_MAX)) begin
                        wrd_nx_s = wrd_r + 8'd1;
                    end else begin
                        wrd_nx_s = wrd_r;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Control state, counters and status outputs; reset clears the previous
    // sample to zero so a nonzero word held through reset becomes an event.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev_r      <= 16'h0000;
            state_r     <= ST_IDLE;
            id_r        <= 3'd0;
            cyc_r       <= 32'd0;
            wrd_r       <= 8'd0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            active_id_r <= 3'd0;
        end else begin
            prev_r      <= checkbits;
            state_r     <= state_nx_s;
            id_r        <= id_nx_s;
            cyc_r       <= cyc_nx_s;
            wrd_r       <= wrd_nx_s;
            err_r       <= err_r | err_set_s;
            busy_r      <= (state_nx_s == ST_ACTIVE);
            active_id_r <= (state_nx_s == ST_ACTIVE) ? id_nx_s : 3'd0;
        end
    end

    // Per-phase record storage: latency, word count and completion flag,
    // written when a phase closes with its own end marker.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            done_r <= 6'b000000;
            for (int i = 0; i < N_PHASE; i++) begin
                lat_r[i]  <= 32'd0;
                wcnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_PHASE; i++) begin
                if (rec_s && (id_r == 3'(i))) begin
                    lat_r[i]  <= cyc_r;
                    wcnt_r[i] <= wrd_r;
                    done_r[i] <= 1'b1;
                end else begin
                    lat_r[i]  <= lat_r[i];
                    wcnt_r[i] <= wcnt_r[i];
                    done_r[i] <= done_r[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback and outputs
    // ------------------------------------------------------------------

    // Combinational record readback; unused selects 6 and 7 read as zero.
    always_comb begin
        rd_lat  = 32'd0;
        rd_wcnt = 8'd0;
        case (rd_sel)
            3'd0: begin rd_lat = lat_r[0]; rd_wcnt = wcnt_r[0]; end
            3'd1: begin rd_lat = lat_r[1]; rd_wcnt = wcnt_r[1]; end
            3'd2: begin rd_lat = lat_r[2]; rd_wcnt = wcnt_r[2]; end
            3'd3: begin rd_lat = lat_r[3]; rd_wcnt = wcnt_r[3]; end
            3'd4: begin rd_lat = lat_r[4]; rd_wcnt = wcnt_r[4]; end
            3'd5: begin rd_lat = lat_r[5]; rd_wcnt = wcnt_r[5]; end
            default: begin
                rd_lat  = 32'd0;
                rd_wcnt = 8'd0;
            end
        endcase
    end

    assign done      = done_r;
    assign busy      = busy_r;
    assign active_id = active_id_r;
    assign err       = err_r;

endmodule
